// File: rtl/mult_accum_pkg.sv
// mult_accum_pkg
// Shared types and constants for the multiply-accumulate stage:
//   - state_t   : FSM state (IDLE = no vector open, ACCUM = vector open)
//   - OPND_W    : operand width of the multiplier inputs
//   - PROD_W    : width of the multiplier product
//   - sat_inc() : increment that sticks at a caller-supplied maximum
package mult_accum_pkg;

  localparam int OPND_W = 4;
  localparam int PROD_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Increment val by one unless it has already reached max.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max);
    return (val >= max) ? max : (val + 32'd1);
  endfunction

endpackage

// File: rtl/array_mult_structural.sv
// array_mult_structural
// Combinational 4x4 unsigned array multiplier. Each row is the multiplicand
// gated by one multiplier bit and shifted to that bit's weight; the rows are
// summed in a ripple chain.
// Ports:
//   i_m [3:0] : multiplicand
//   i_q [3:0] : multiplier
//   o_p [7:0] : product i_m * i_q (0..225)
module array_mult_structural
  import mult_accum_pkg::*;
(
  input  logic [OPND_W-1:0] i_m,
  input  logic [OPND_W-1:0] i_q,
  output logic [PROD_W-1:0] o_p
);

  // w_row[k] holds the sum of the first k partial-product rows.
  logic [PROD_W-1:0] w_row [0:OPND_W];

  assign w_row[0] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < OPND_W; gi++) begin : g_row
      logic [PROD_W-1:0] w_pp;
      assign w_pp          = PROD_W'({{(PROD_W-OPND_W){1'b0}}, i_m & {OPND_W{i_q[gi]}}} << gi);
      assign w_row[gi + 1] = w_row[gi] + w_pp;
    end
  endgenerate

  assign o_p = w_row[OPND_W];

endmodule

// File: rtl/mult_accum_seq.sv
// mult_accum_seq
// Sequential multiply-accumulate stage. Operand pairs arrive on a valid/ready
// handshake, are multiplied combinationally and summed into a wide
// accumulator. The beat flagged in_last closes the vector and loads the
// result (sum, term count, sticky overflow) into a held output slot.
// Parameters:
//   ACC_W : accumulator/result width (intended range 8..32)
//   CNT_W : term-counter width; the counter saturates at all-ones
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   : operand beat handshake
//   in_m, in_q          : 4-bit unsigned operands
//   in_last             : beat is the final term of the vector
//   clr                 : synchronous abort of the open vector
//   out_valid/out_ready : result handshake
//   out_acc/out_cnt/out_ovf : registered result, term count, overflow flag
module mult_accum_seq
  import mult_accum_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] in_m,
  input  logic [OPND_W-1:0] in_q,
  input  logic              in_last,
  input  logic              clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_ovf
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_acc;
  logic [CNT_W-1:0] r_out_cnt;
  logic             r_out_ovf;

  logic [PROD_W-1:0] w_prod;
  logic              w_accept;
  logic [ACC_W-1:0]  w_acc_base;
  logic [CNT_W-1:0]  w_cnt_base;
  logic              w_ovf_base;
  logic [ACC_W:0]    w_sum;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_ovf_next;

  array_mult_structural u_mult (
    .i_m (in_m),
    .i_q (in_q),
    .o_p (w_prod)
  );

  // A beat may enter whenever the output slot is empty or being drained in
  // this same cycle; clr blocks entry for the cycle it is asserted.
  assign in_ready = (!r_out_valid || out_ready) && !clr;
  assign w_accept = in_valid && in_ready;

  // In IDLE no vector is open, so the running totals start from zero.
  assign w_acc_base = (r_state == IDLE) ? '0   : r_acc;
  assign w_cnt_base = (r_state == IDLE) ? '0   : r_cnt;
  assign w_ovf_base = (r_state == IDLE) ? 1'b0 : r_ovf;

  // One extra bit so the carry out of the accumulator can be observed.
  assign w_sum      = {1'b0, w_acc_base} + {{(ACC_W + 1 - PROD_W){1'b0}}, w_prod};
  assign w_cnt_inc  = CNT_W'(sat_inc(32'(w_cnt_base), CNT_MAX));
  assign w_ovf_next = w_ovf_base | w_sum[ACC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_acc   <= '0;
      r_out_cnt   <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      // Drain first; a result loaded below in the same cycle overrides this.
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (clr) begin
        r_state <= IDLE;
        r_acc   <= '0;
        r_cnt   <= '0;
        r_ovf   <= 1'b0;
      end else if (w_accept) begin
        if (in_last) begin
          r_out_acc   <= w_sum[ACC_W-1:0];
          r_out_cnt   <= w_cnt_inc;
          r_out_ovf   <= w_ovf_next;
          r_out_valid <= 1'b1;
          r_state     <= IDLE;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_ovf       <= 1'b0;
        end else begin
          r_state <= ACCUM;
          r_acc   <= w_sum[ACC_W-1:0];
          r_cnt   <= w_cnt_inc;
          r_ovf   <= w_ovf_next;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_acc   = r_out_acc;
  assign out_cnt   = r_out_cnt;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_mult_accum_seq.sv
// tb_mult_accum_seq
// Directed testbench for mult_accum_seq built with a narrow accumulator
// (ACC_W=8) so overflow is reachable, and CNT_W=4 so counter saturation is
// reachable in a short vector. Expected results are pushed into a scoreboard
// queue as each vector is issued; a monitor pops and compares on every output
// handshake.
module tb_mult_accum_seq;

  localparam int ACC_W = 8;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } exp_t;

  logic             clk;
  logic             clk_en;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_m;
  logic [3:0]       in_q;
  logic             in_last;
  logic             clr;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_cnt;
  logic             out_ovf;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  mult_accum_seq #(
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_m      (in_m),
    .in_q      (in_q),
    .in_last   (in_last),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_cnt   (out_cnt),
    .out_ovf   (out_ovf)
  );

  // Gateable clock so the asynchronous reset can be exercised with clk stopped.
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end else begin
      $display("ok   %s value=%0d t=%0t", name, act, $time);
    end
  endtask

  task automatic expect_result(input int acc, input int cnt, input int ovf);
    exp_t e;
    e.acc = ACC_W'(acc);
    e.cnt = CNT_W'(cnt);
    e.ovf = ovf[0];
    sb.push_back(e);
  endtask

  // Present one beat and hold it until the DUT accepts it (bounded).
  task automatic send(input logic [3:0] m, input logic [3:0] q, input logic last);
    int   n;
    logic ok;
    in_valid = 1'b1;
    in_m     = m;
    in_q     = q;
    in_last  = last;
    n        = 0;
    ok       = 1'b0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready_low required=accept m=%0d q=%0d", m, q);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Monitor: every output handshake is matched against the scoreboard.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=acc%0d/cnt%0d required=no_output", out_acc, out_cnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_acc", 32'(out_acc), 32'(e.acc));
        chk("res_cnt", 32'(out_cnt), 32'(e.cnt));
        chk("res_ovf", 32'(out_ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    clk_en    = 1'b1;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_m      = '0;
    in_q      = '0;
    in_last   = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_acc",   32'(out_acc),   0);
    chk("rst_out_cnt",   32'(out_cnt),   0);
    chk("rst_out_ovf",   32'(out_ovf),   0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;

    // Single-term vector: 15*15
    expect_result(225, 1, 0);
    send(4'd15, 4'd15, 1'b1);
    idle();
    chk("single_valid_rise", 32'(out_valid), 1);
    @(posedge clk);
    #1;
    chk("single_valid_fall", 32'(out_valid), 0);

    // Four-beat vector at full rate: 12+30+56+18 = 116
    expect_result(116, 4, 0);
    send(4'd3, 4'd4, 1'b0);
    send(4'd5, 4'd6, 1'b0);
    send(4'd7, 4'd8, 1'b0);
    send(4'd2, 4'd9, 1'b1);
    idle();
    chk("four_valid_rise", 32'(out_valid), 1);
    @(posedge clk);
    #1;
    chk("four_valid_one_cycle", 32'(out_valid), 0);

    // Overflow: 225+225 = 450 -> 194 with ovf; next vector clears ovf.
    // The second vector starts in the cycle the first result is taken.
    expect_result(194, 2, 1);
    send(4'd15, 4'd15, 1'b0);
    send(4'd15, 4'd15, 1'b1);
    expect_result(1, 1, 0);
    send(4'd1, 4'd1, 1'b1);
    idle();

    // Counter saturation: 20 beats of 1*1 -> acc 20, cnt sticks at 15
    expect_result(20, 15, 0);
    for (int i = 0; i < 19; i++) send(4'd1, 4'd1, 1'b0);
    send(4'd1, 4'd1, 1'b1);
    idle();
    @(posedge clk);
    #1;

    // Back-pressure: result 25 held for 5 cycles with a beat waiting
    out_ready = 1'b0;
    expect_result(25, 1, 0);
    send(4'd5, 4'd5, 1'b1);
    in_valid = 1'b1;
    in_m     = 4'd2;
    in_q     = 4'd2;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready),  0);
      chk("bp_valid",    32'(out_valid), 1);
      chk("bp_acc",      32'(out_acc),   25);
      chk("bp_cnt",      32'(out_cnt),   1);
    end
    @(posedge clk);
    #1;
    expect_result(4, 1, 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    idle();
    chk("bp_new_valid", 32'(out_valid), 1);
    chk("bp_new_acc",   32'(out_acc),   4);

    // clr mid-vector: 9+9 discarded, beat during clr refused, result = 1*2
    expect_result(2, 1, 0);
    send(4'd3, 4'd3, 1'b0);
    send(4'd3, 4'd3, 1'b0);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_m     = 4'd1;
    in_q     = 4'd2;
    in_last  = 1'b1;
    @(negedge clk);
    chk("clr_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    send(4'd1, 4'd2, 1'b1);
    idle();
    @(posedge clk);
    #1;

    // Asynchronous reset mid-vector with the clock stopped
    send(4'd3, 4'd3, 1'b0);
    send(4'd3, 4'd3, 1'b0);
    idle();
    clk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_out_acc",   32'(out_acc),   0);
    chk("arst_out_cnt",   32'(out_cnt),   0);
    chk("arst_out_ovf",   32'(out_ovf),   0);
    #2;
    rst_n = 1'b1;
    #2;
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    expect_result(16, 1, 0);
    send(4'd4, 4'd4, 1'b1);
    idle();

    // Let the monitor drain everything still expected
    begin
      int n;
      n = 0;
      while (sb.size() != 0 && n < 20) begin
        @(posedge clk);
        n++;
      end
    end
    chk("scoreboard_empty", 32'(sb.size()), 0);
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
